// File: rtl/scan_ctrl_pkg.sv
// scan_ctrl_pkg: register offsets, field positions and ramp state encoding shared by scan_ctrl_regs
package scan_ctrl_pkg;
  localparam logic [7:0] OFF_COMMIT = 8'h00;
  localparam logic [7:0] OFF_SCAN = 8'h01;
  localparam logic [7:0] OFF_LED = 8'h02;
  localparam logic [7:0] OFF_DAC = 8'h03;
  localparam logic [7:0] OFF_RAMP = 8'h04;
  localparam logic [7:0] OFF_MTR = 8'h10;
  localparam int SCAN_EN_BIT = 0;
  localparam int SCAN_SUB_LSB = 4;
  localparam int SCAN_FR_LSB = 8;
  localparam int DAC_GAIN_LSB = 0;
  localparam int DAC_OFF_LSB = 16;
  localparam int MTR_EN_BIT = 0;
  localparam int MTR_DIR_BIT = 1;
  localparam int MTR_SPD_LSB = 2;
  typedef enum logic [1:0] {RAMP_IDLE, RAMP_RUN, RAMP_REV, RAMP_STOP} ramp_state_e;
endpackage

// File: rtl/mtr_ramp.sv
// mtr_ramp: one motor channel; ramps speed toward target per tick, decelerates before reversing or stopping
module mtr_ramp
  import scan_ctrl_pkg::*;
#(
  parameter int SPD_W = 16
) (
  input  logic             bus_clk,
  input  logic             nrst,
  input  logic             tick,
  input  logic             en,
  input  logic             dir,
  input  logic             stop,
  input  logic [SPD_W-1:0] target,
  input  logic [SPD_W-1:0] step,
  output logic             mtr_en,
  output logic             mtr_dir,
  output logic [SPD_W-1:0] speed
);
  ramp_state_e state, state_nx;
  logic [SPD_W-1:0] speed_nx, diff, toward, dec;
  logic en_nx, dir_nx, halt;
  always_comb begin
    halt = !en || stop;
    diff = target > speed ? target - speed : speed - target;
    toward = (step == '0 || step >= diff) ? target : target > speed ? speed + step : speed - step;
    dec = (step == '0 || step >= speed) ? '0 : speed - step;
    state_nx = state;
    speed_nx = speed;
    en_nx = mtr_en;
    dir_nx = mtr_dir;
    case (state)
      RAMP_IDLE:
        if (!halt) begin
          state_nx = RAMP_RUN;
          en_nx = 1'b1;
          dir_nx = dir;
        end
      RAMP_RUN:
        if (halt) state_nx = RAMP_STOP;
        else if (dir != mtr_dir) begin
          if (speed == '0) dir_nx = dir;
          else state_nx = RAMP_REV;
        end else if (tick) speed_nx = toward;
      RAMP_REV:
        if (halt) state_nx = RAMP_STOP;
        else if (speed == '0) begin
          state_nx = RAMP_RUN;
          dir_nx = dir;
        end else if (tick) speed_nx = dec;
      default:
        if (speed == '0) begin
          state_nx = RAMP_IDLE;
          en_nx = 1'b0;
        end else if (tick) speed_nx = dec;
    endcase
  end
  always_ff @(posedge bus_clk or negedge nrst)
    if (!nrst) begin
      state <= RAMP_IDLE;
      speed <= '0;
      mtr_en <= 1'b0;
      mtr_dir <= 1'b0;
    end else begin
      state <= state_nx;
      speed <= speed_nx;
      mtr_en <= en_nx;
      mtr_dir <= dir_nx;
    end
endmodule

// File: rtl/scan_ctrl_regs.sv
// scan_ctrl_regs: shadow/commit control registers feeding motor ramps, scan, LED and DAC settings
// Optional write watchdog is built only when SCAN_CTRL_WDOG_EN is defined.
module scan_ctrl_regs
  import scan_ctrl_pkg::*;
#(
  parameter int          NUM_MTR     = 2,
  parameter int          SPD_W       = 16,
  parameter int          PWM_W       = 12,
  parameter int          RAMP_DIV    = 1000,
  parameter int          WDOG_CYCLES = 10_000_000,
  parameter logic [55:0] BASE_ADDR   = 56'h0
) (
  input  logic                     bus_clk,
  input  logic                     nrst,
  input  logic                     bus_valid,
  input  logic [63:0]              bus_addr,
  input  logic [31:0]              bus_data,
  input  logic [31:0]              bus_gpreg,
  output logic [NUM_MTR-1:0]       mtr_en,
  output logic [NUM_MTR-1:0]       mtr_dir,
  output logic [NUM_MTR*SPD_W-1:0] mtr_speed,
  output logic [PWM_W-1:0]         led_pwm_val,
  output logic                     scan_en,
  output logic [3:0]               scan_sub_smpl,
  output logic [7:0]               scan_fr,
  output logic [15:0]              dac_gain,
  output logic [15:0]              dac_offset,
  output logic                     wdog_trip
);
  localparam int RC_W = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;
  typedef struct packed {
    logic                          scan_en;
    logic [3:0]                    sub_smpl;
    logic [7:0]                    fr;
    logic [PWM_W-1:0]              led;
    logic [15:0]                   gain;
    logic [15:0]                   offset;
    logic [SPD_W-1:0]              step;
    logic [NUM_MTR-1:0]            men;
    logic [NUM_MTR-1:0]            mdir;
    logic [NUM_MTR-1:0][SPD_W-1:0] tgt;
  } regs_t;
  regs_t shadow, active;
  logic wr, tick, trip, stop, unused_gpreg;
  logic [7:0] off;
  logic [RC_W-1:0] rcnt;
  assign wr = bus_valid && bus_addr[63:8] == BASE_ADDR;
  assign off = bus_addr[7:0];
  assign tick = rcnt == RC_W'(RAMP_DIV - 1);
  assign stop = bus_gpreg[0] | trip;
  assign unused_gpreg = ^bus_gpreg[31:1];
  always_ff @(posedge bus_clk or negedge nrst)
    if (!nrst) rcnt <= '0;
    else rcnt <= tick ? '0 : rcnt + 1'b1;
  // COMMIT copies the shadow as it stood before this edge
  always_ff @(posedge bus_clk or negedge nrst)
    if (!nrst) begin
      shadow <= '0;
      active <= '0;
    end else if (wr) begin
      if (off == OFF_COMMIT) active <= shadow;
      if (off == OFF_SCAN) begin
        shadow.scan_en <= bus_data[SCAN_EN_BIT];
        shadow.sub_smpl <= bus_data[SCAN_SUB_LSB +: 4];
        shadow.fr <= bus_data[SCAN_FR_LSB +: 8];
      end
      if (off == OFF_LED) shadow.led <= bus_data[PWM_W-1:0];
      if (off == OFF_DAC) begin
        shadow.gain <= bus_data[DAC_GAIN_LSB +: 16];
        shadow.offset <= bus_data[DAC_OFF_LSB +: 16];
      end
      if (off == OFF_RAMP) shadow.step <= bus_data[SPD_W-1:0];
      for (int i = 0; i < NUM_MTR; i++)
        if (off == OFF_MTR + 8'(i)) begin
          shadow.men[i] <= bus_data[MTR_EN_BIT];
          shadow.mdir[i] <= bus_data[MTR_DIR_BIT];
          shadow.tgt[i] <= bus_data[MTR_SPD_LSB +: SPD_W];
        end
    end
`ifdef SCAN_CTRL_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wcnt;
  // counter saturates at WDOG_CYCLES so the trip stays sticky until the next write
  always_ff @(posedge bus_clk or negedge nrst)
    if (!nrst) begin
      wcnt <= '0;
      trip <= 1'b0;
    end else if (wr) begin
      wcnt <= '0;
      trip <= 1'b0;
    end else if (wcnt != WD_W'(WDOG_CYCLES)) begin
      wcnt <= wcnt + 1'b1;
      trip <= wcnt == WD_W'(WDOG_CYCLES - 1);
    end
`else
  assign trip = 1'b0;
`endif
  assign wdog_trip = trip;
  assign scan_en = active.scan_en & ~trip;
  assign scan_sub_smpl = active.sub_smpl;
  assign scan_fr = active.fr;
  assign led_pwm_val = active.led;
  assign dac_gain = active.gain;
  assign dac_offset = active.offset;
  for (genvar g = 0; g < NUM_MTR; g++) begin : g_ch
    mtr_ramp #(.SPD_W(SPD_W)) u_ch (
      .bus_clk(bus_clk),
      .nrst(nrst),
      .tick(tick),
      .en(active.men[g]),
      .dir(active.mdir[g]),
      .stop(stop),
      .target(active.tgt[g]),
      .step(active.step),
      .mtr_en(mtr_en[g]),
      .mtr_dir(mtr_dir[g]),
      .speed(mtr_speed[g*SPD_W +: SPD_W])
    );
  end
endmodule

// File: tb/tb_scan_ctrl_regs.sv
// tb_scan_ctrl_regs: directed scenarios plus randomized writes checked every cycle against a behavioural model
module tb_scan_ctrl_regs;
  localparam int NM = 2, SW = 16, PW = 12, RD = 4, WD = 50;
  localparam logic [55:0] BASE = 56'h12_3456_789A_BCDE;
  localparam int IDLE = 0, RUN = 1, REV = 2, STOP = 3;
  logic clk = 0, nrst = 1, bus_valid = 0;
  logic [63:0] bus_addr = '0;
  logic [31:0] bus_data = '0, bus_gpreg = '0;
  logic [NM-1:0] mtr_en, mtr_dir;
  logic [NM*SW-1:0] mtr_speed;
  logic [PW-1:0] led_pwm_val;
  logic scan_en, wdog_trip;
  logic [3:0] scan_sub_smpl;
  logic [7:0] scan_fr;
  logic [15:0] dac_gain, dac_offset;
  int checks = 0, errors = 0;
  bit keep = 1;
  int seq[$], at[$], want_q[$];
  logic en_at0, dir_at0;

  scan_ctrl_regs #(.NUM_MTR(NM), .SPD_W(SW), .PWM_W(PW), .RAMP_DIV(RD), .WDOG_CYCLES(WD),
    .BASE_ADDR(BASE)) dut (
    .bus_clk(clk), .nrst(nrst), .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_data(bus_data),
    .bus_gpreg(bus_gpreg), .mtr_en(mtr_en), .mtr_dir(mtr_dir), .mtr_speed(mtr_speed),
    .led_pwm_val(led_pwm_val), .scan_en(scan_en), .scan_sub_smpl(scan_sub_smpl), .scan_fr(scan_fr),
    .dac_gain(dac_gain), .dac_offset(dac_offset), .wdog_trip(wdog_trip));

  always #5 clk = ~clk;

  typedef struct packed {
    bit sen; bit [3:0] sub; bit [7:0] fr; bit [PW-1:0] led; bit [15:0] gain, offs; bit [SW-1:0] step;
    bit [NM-1:0] men, mdir; bit [NM-1:0][SW-1:0] tgt;
  } cfg_t;
  cfg_t sh, ac;
  int st[NM], spd[NM], cyc, quiet;
  bit men_o[NM], dir_o[NM], trip;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, want, $time);
    end
  endtask

  // each channel moves toward a goal: the target while running, zero while reversing or stopping
  task automatic model_step();
    bit wr, tick, halt, mism;
    int off, step, goal, d, mv;
    wr = bus_valid && bus_addr[63:8] == BASE;
    off = int'(bus_addr[7:0]);
    tick = (cyc % RD) == RD - 1;
    cyc++;
    step = int'(ac.step);
    for (int i = 0; i < NM; i++) begin
      halt = !ac.men[i] || bus_gpreg[0] || trip;
      mism = ac.mdir[i] != dir_o[i];
      if (st[i] == IDLE) begin
        if (!halt) begin st[i] = RUN; men_o[i] = 1; dir_o[i] = ac.mdir[i]; end
      end else if (halt && st[i] != STOP) st[i] = STOP;
      else if (st[i] == STOP && spd[i] == 0) begin st[i] = IDLE; men_o[i] = 0; end
      else if (st[i] != STOP && spd[i] == 0 && (st[i] == REV || mism)) begin
        st[i] = RUN; dir_o[i] = ac.mdir[i];
      end else if (st[i] == RUN && mism) st[i] = REV;
      else if (tick) begin
        goal = st[i] == RUN ? int'(ac.tgt[i]) : 0;
        d = goal > spd[i] ? goal - spd[i] : spd[i] - goal;
        mv = (step == 0 || step > d) ? d : step;
        spd[i] = goal > spd[i] ? spd[i] + mv : spd[i] - mv;
      end
    end
    if (wr) begin
      if (off == 0) ac = sh;
      else if (off == 1) begin sh.sen = bus_data[0]; sh.sub = bus_data[7:4]; sh.fr = bus_data[15:8]; end
      else if (off == 2) sh.led = bus_data[PW-1:0];
      else if (off == 3) begin sh.gain = bus_data[15:0]; sh.offs = bus_data[31:16]; end
      else if (off == 4) sh.step = bus_data[SW-1:0];
      else if (off >= 16 && off < 16 + NM) begin
        sh.men[off-16] = bus_data[0]; sh.mdir[off-16] = bus_data[1]; sh.tgt[off-16] = bus_data[SW+1:2];
      end
    end
`ifdef SCAN_CTRL_WDOG_EN
    if (wr) begin quiet = 0; trip = 0; end
    else begin quiet++; if (quiet >= WD) trip = 1; end
`endif
  endtask

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sh = '0; ac = '0; cyc = 0; quiet = 0; trip = 0;
      for (int i = 0; i < NM; i++) begin st[i] = IDLE; spd[i] = 0; men_o[i] = 0; dir_o[i] = 0; end
    end else model_step();
  end

  always @(negedge clk) begin
    logic [NM*SW-1:0] e_spd;
    logic [NM-1:0] e_en, e_dir;
    for (int i = 0; i < NM; i++) begin
      e_spd[i*SW +: SW] = SW'(spd[i]); e_en[i] = men_o[i]; e_dir[i] = dir_o[i];
    end
    chk("mtr_en", 64'(mtr_en), 64'(e_en));
    chk("mtr_dir", 64'(mtr_dir), 64'(e_dir));
    chk("mtr_speed", 64'(mtr_speed), 64'(e_spd));
    chk("led", 64'(led_pwm_val), 64'(ac.led));
    chk("scan_en", 64'(scan_en), 64'(ac.sen & !trip));
    chk("scan_sub", 64'(scan_sub_smpl), 64'(ac.sub));
    chk("scan_fr", 64'(scan_fr), 64'(ac.fr));
    chk("dac_gain", 64'(dac_gain), 64'(ac.gain));
    chk("dac_offset", 64'(dac_offset), 64'(ac.offs));
    chk("wdog_trip", 64'(wdog_trip), 64'(trip));
  end

  task automatic idle_bus();
    bus_valid = keep;
    bus_addr = {BASE, 8'h0F};
    bus_data = '0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [55:0] base = BASE);
    bus_valid = 1; bus_addr = {base, off}; bus_data = d;
    @(posedge clk); #1;
    idle_bus();
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic capture(input int n);
    int last;
    bit z;
    seq.delete(); at.delete(); last = -1; z = 0; en_at0 = 0; dir_at0 = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (int'(mtr_speed[SW-1:0]) != last) begin
        last = int'(mtr_speed[SW-1:0]);
        seq.push_back(last); at.push_back(k);
        if (last == 0 && !z) begin z = 1; en_at0 = mtr_en[0]; dir_at0 = mtr_dir[0]; end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_seq(input string nm);
    chk({nm, "_len"}, 64'(seq.size()), 64'(want_q.size()));
    for (int k = 0; k < want_q.size() && k < seq.size(); k++) chk(nm, 64'(seq[k]), 64'(want_q[k]));
  endtask

  initial begin
    int quiet_left, sel;
    logic [7:0] o8;
    #2 nrst = 0;
    repeat (3) @(negedge clk);
    chk("rst_speed", 64'(mtr_speed), 0);
    chk("rst_en", 64'(mtr_en), 0);
    chk("rst_scan_en", 64'(scan_en), 0);
    chk("rst_trip", 64'(wdog_trip), 0);
    #2 nrst = 1;
    idle_bus();
    @(posedge clk); #1;
    wr(8'h01, 32'h0000_1A31);
    @(negedge clk);
    chk("scan_no_commit", 64'(scan_en), 0);
    @(posedge clk); #1;
    wr(8'h00, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("scan_commit_en", 64'(scan_en), 1);
    chk("scan_commit_sub", 64'(scan_sub_smpl), 3);
    chk("scan_commit_fr", 64'(scan_fr), 8'h1A);
    @(posedge clk); #1;
    wr(8'h04, 10);
    wr(8'h10, (25 << 2) | 1);
    wr(8'h00, 0);
    capture(24);
    want_q = {0, 10, 20, 25};
    chk_seq("ramp_up");
    if (at.size() == 4) begin
      chk("ramp_gap1", 64'(at[2] - at[1]), RD);
      chk("ramp_gap2", 64'(at[3] - at[2]), RD);
    end
    wr(8'h10, (25 << 2) | 3);
    wr(8'h00, 0);
    capture(48);
    want_q = {25, 15, 5, 0, 10, 20, 25};
    chk_seq("reverse");
    chk("rev_dir_at0", 64'(dir_at0), 0);
    chk("rev_dir_end", 64'(mtr_dir[0]), 1);
    bus_gpreg = 32'h1;
    capture(30);
    want_q = {25, 15, 5, 0};
    chk_seq("soft_stop");
    chk("stop_en_at0", 64'(en_at0), 1);
    chk("stop_en_end", 64'(mtr_en[0]), 0);
    bus_gpreg = 32'h0;
    cycles(20);
    wr(8'h10 + 8'(NM), 32'hFFFF_FFFF);
    wr(8'h01, 32'h0, BASE ^ 56'h1);
    wr(8'h00, 32'h0, BASE ^ 56'h100);
    wr(8'h00, 0);
    @(negedge clk);
    chk("ignored_scan_en", 64'(scan_en), 1);
    chk("ignored_fr", 64'(scan_fr), 8'h1A);
    @(posedge clk); #1;
    keep = 0;
    idle_bus();
    cycles(80);
`ifdef SCAN_CTRL_WDOG_EN
    chk("wdog_trip_set", 64'(wdog_trip), 1);
    chk("wdog_scan_off", 64'(scan_en), 0);
    chk("wdog_mtr_off", 64'(mtr_en[0]), 0);
    chk("wdog_speed0", 64'(mtr_speed[SW-1:0]), 0);
`else
    chk("no_wdog_trip", 64'(wdog_trip), 0);
`endif
    keep = 1;
    wr(8'h0F, 0);
    @(negedge clk);
    chk("wdog_cleared", 64'(wdog_trip), 0);
    @(posedge clk); #1;
    wr(8'h10, (200 << 2) | 3);
    wr(8'h00, 0);
    cycles(7);
    chk("pre_rst_moving", 64'(mtr_speed[SW-1:0] != 0), 1);
    #2 nrst = 0;
    #1;
    chk("mid_rst_speed", 64'(mtr_speed), 0);
    chk("mid_rst_en", 64'(mtr_en), 0);
    @(negedge clk); #2 nrst = 1;
    @(posedge clk); #1;
    quiet_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (quiet_left > 0) begin
        quiet_left--;
        bus_valid = 0;
      end else begin
        if ($urandom_range(0, 199) == 0) quiet_left = $urandom_range(40, 70);
        if ($urandom_range(0, 99) == 0) bus_gpreg = $urandom;
        sel = $urandom_range(0, 10);
        o8 = sel < 5 ? 8'(sel) : sel < 8 ? 8'(16 + sel - 5) : 8'($urandom);
        bus_valid = $urandom_range(0, 2) == 0;
        bus_addr = {($urandom_range(0, 9) == 0) ? BASE ^ 56'h100 : BASE, o8};
        bus_data = o8 == 8'h04 ? $urandom_range(0, 30) :
                   (o8 >= 8'h10 && o8 < 8'h13) ? (($urandom_range(0, 200) << 2) | $urandom_range(0, 3)) :
                   $urandom;
      end
      @(posedge clk); #1;
    end
    bus_valid = 0;
    cycles(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/scan_ctrl_regs.md
SCAN_CTRL_REGS -- requirements
Module: scan_ctrl_regs

Interface
REQ-001 SHALL have parameter NUM_MTR, default 2, number of motor channels (1..8).
REQ-002 SHALL have parameter SPD_W, default 16, motor speed width (1..29).
REQ-003 SHALL have parameter PWM_W, default 12, LED PWM value width (1..32).
REQ-004 SHALL have parameter RAMP_DIV, default 1000, number of bus_clk cycles per ramp tick (>=1).
REQ-005 SHALL have parameter WDOG_CYCLES, default 10_000_000, number of bus_clk cycles without a write before the watchdog trips.
REQ-006 SHALL have parameter BASE_ADDR, default 56'h0, the block base compared against bus_addr[63:8].
REQ-007 SHALL have ports, one per line:
- bus_clk  in  1  sole clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- bus_valid  in  1  write strobe, one write per asserted cycle.
- bus_addr  in  64  write address.
- bus_data  in  32  write data.
- bus_gpreg  in  32  general-purpose control; bit0 = global soft stop.
- mtr_en  out  NUM_MTR  per-channel motor enable.
- mtr_dir  out  NUM_MTR  per-channel direction.
- mtr_speed  out  NUM_MTR*SPD_W  per-channel ramped speed; channel i at [i*SPD_W +: SPD_W].
- led_pwm_val  out  PWM_W  LED PWM value.
- scan_en  out  1  scan enable.
- scan_sub_smpl  out  4  sub-sample setting.
- scan_fr  out  8  frame-rate setting.
- dac_gain  out  16  DAC gain.
- dac_offset  out  16  DAC offset.
- wdog_trip  out  1  sticky watchdog-trip flag.

Function
REQ-008 SHALL decode a write when bus_valid=1 and bus_addr[63:8]==BASE_ADDR, using offset bus_addr[7:0]; all other cycles are ignored.
REQ-009 SHALL accept writes into shadow registers at these offsets: 0x01 SCAN ([0] en, [7:4] sub_smpl, [15:8] fr); 0x02 LED ([PWM_W-1:0]); 0x03 DAC ([15:0] gain, [31:16] offset); 0x04 RAMP step ([SPD_W-1:0]); 0x10+i MTR i ([0] en, [1] dir, [SPD_W+1:2] target speed). Writes to undefined offsets, and to 0x10+i with i>=NUM_MTR, SHALL be ignored.
REQ-010 SHALL copy all shadow registers to the active registers on the clock edge of a decoded write to offset 0x00 (COMMIT), regardless of data; non-motor outputs SHALL reflect the active registers one cycle after that edge.
REQ-011 SHALL, when a COMMIT and a shadow write occur in the same cycle, commit the pre-write shadow contents; this case is impossible for a single write port and needs no further handling.
REQ-012 SHALL generate a ramp tick once every RAMP_DIV cycles from a free-running counter that wraps to 0 after RAMP_DIV-1.
REQ-013 SHALL give each motor channel four states: IDLE (speed 0, mtr_en 0), RUN (speed moves toward target), REV (decelerating to 0 before a direction change), STOP (decelerating to 0 before disabling).
REQ-014 SHALL, on each ramp tick in RUN, change speed toward target by min(step, |target-speed|); step=0 SHALL apply target immediately with no ramp.
REQ-015 SHALL, when the active dir differs from mtr_dir while speed>0, enter REV; mtr_dir SHALL update only on reaching speed 0, then return to RUN.
REQ-016 SHALL, when active en=0, soft stop is active (bus_gpreg[0]=1), or the watchdog has tripped, enter STOP; mtr_en SHALL deassert in the cycle after speed reaches 0, then go to IDLE.
REQ-017 SHALL transition from IDLE to RUN when en=1 and no stop condition is active; mtr_en SHALL assert on entering RUN, and mtr_dir SHALL load from the active dir.

Reset
REQ-018 SHALL, while nrst=0, asynchronously clear all shadow and active registers, counters, and outputs to 0, including wdog_trip, and place every channel in IDLE.
REQ-019 SHALL, when reset is asserted mid-ramp, drop speed to 0 immediately with no deceleration.

Configuration
REQ-020 SHALL include the watchdog when macro SCAN_CTRL_WDOG_EN is defined: a counter clears on every decoded write; on reaching WDOG_CYCLES it sets wdog_trip, forces scan_en to 0, and sends all channels to STOP; the next decoded write clears wdog_trip.
REQ-021 SHALL, without SCAN_CTRL_WDOG_EN, contain no watchdog logic and tie wdog_trip to 0.

Structure
REQ-022 SHALL place the register offsets, field positions, and the ramp state enum in shared package scan_ctrl_pkg.
REQ-023 SHALL implement one channel per instance of sub-module mtr_ramp, generated NUM_MTR times.

Verification
REQ-024 SHALL cover: write 0x01=0x0000_1A31 with no COMMIT -> scan_en stays 0; write 0x00 -> next cycle scan_en=1, scan_sub_smpl=3, scan_fr=0x1A.
REQ-025 SHALL cover: RAMP_DIV=4, step=10, MTR0 en=1 with target 25, then COMMIT -> speed 10, 20, 25 on successive ticks (4 cycles apart).
REQ-026 SHALL cover: channel at speed 25 with step 10, commit dir flip -> speed 15, 5, 0 with mtr_dir unchanged, then dir flips and speed ramps back to 25.
REQ-027 SHALL cover: bus_gpreg[0]=1 while running -> speed ramps to 0, mtr_en drops the next cycle, channel goes to IDLE.
REQ-028 SHALL cover: with SCAN_CTRL_WDOG_EN and WDOG_CYCLES=50, no writes for 50 cycles -> wdog_trip=1, scan_en=0, motors stop; one write -> wdog_trip=0.
REQ-029 SHALL cover: write to 0x10+NUM_MTR, and a write with bus_addr[63:8]!=BASE_ADDR -> no state change.
